mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side counterpart of the pipeline control word. Consumes the MEM-stage mem_read/mem_write/funct3 intent and drives the data-memory bus handshake.
- Stores: shifts and replicates store data and generates the byte enable.
- Loads: extracts the addressed bytes and sign/zero-extends them.
- Stalls the pipeline until the bus responds. Sits between the MEM stage and the data cache/memory port.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles awaiting mem_resp before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage holds a valid instruction
- req_read  in  1  control word mem_read
- req_write  in  1  control word mem_write
- req_funct3  in  3  load_funct3_t / store_funct3_t
- req_addr  in  32  effective byte address (ALU out)
- req_wdata  in  32  rs2 value
- stall  out  1  hold pipeline (combinational)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_err  out  1  misaligned / illegal funct3 / read+write both set / timeout; valid with resp_valid
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_address  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  aligned store data
- mem_byte_enable  out  4  rv32i_mem_wmask
- mem_resp  in  1  bus completion
- mem_rdata  in  32  bus read data

Behaviour:
- Reset values: state IDLE; mem_read, mem_write, resp_valid and resp_err 0; mem_address, mem_wdata, resp_rdata 0; mem_byte_enable 0; timeout counter 0.
- Operation: op = req_valid & (req_read | req_write).
- stall = op & (state != DONE).
- States:
  - IDLE:
    - On op, capture funct3, addr, offset = addr[1:0], read flag and wdata.
    - If the request is illegal (read&write; load funct3 in {011,110,111}; store funct3 >= 011; lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0), go to DONE with err=1 and issue no bus access.
    - Otherwise go to BUSY, registering mem_read/mem_write=1, mem_address, mem_wdata and mem_byte_enable.
  - BUSY:
    - Bus outputs held stable until mem_resp.
    - On mem_resp: strobes drop next cycle, capture the extended load data, go to DONE.
    - Counter increments each BUSY cycle without mem_resp. If it reaches TIMEOUT_CYCLES (nonzero), drop strobes, go to DONE with err=1 and rdata=0.
  - DONE:
    - resp_valid=1 for exactly this cycle; stall=0 so the pipeline advances at this edge.
    - Next state is IDLE unconditionally; a new request is taken the following cycle.
- Latency: with mem_resp in the first BUSY cycle, the request is accepted in cycle 0, BUSY in cycle 1, DONE in cycle 2. That is 3 cycles with 2 stall cycles. Illegal requests complete in 2 cycles.
- Store alignment:
  - sb: enable = 4'b0001 << off; wdata = byte replicated ×4.
  - sh: enable = 4'b0011 << off; wdata = half replicated ×2.
  - sw: enable = 4'b1111.
- Load extraction:
  - lb/lbu: byte mem_rdata[8*off +: 8], sign/zero-extended.
  - lh/lhu: half mem_rdata[16*off[1] +: 16], sign/zero-extended.
  - lw: whole word.
- For reads, mem_byte_enable = 4'b1111 and mem_wdata = 0.
- A mem_resp arriving in IDLE or DONE is ignored.
- rst in any state (including BUSY) forces IDLE within one edge; strobes are 0 the next cycle. Late mem_resp is ignored.
- req_* changes while in BUSY are ignored; the captured request is authoritative.

Decomposition:
- Add to the shared types package:
  - mau_state_t enum (IDLE, BUSY, DONE).
  - The existing load_funct3_t / store_funct3_t and rv32i_mem_wmask, reused.
- One sub-module, mem_align: combinational store shift/byte-enable and load extract/extend. The FSM, capture registers and timeout counter stay in mem_access_unit.

Test Plan:
- sb: addr=0x1003, wdata=0x000000AB, funct3=000 -> mem_address=0x1000, byte_enable=4'b1000, mem_wdata=0xABABABAB, one mem_write cycle, resp_valid in the cycle after mem_resp, err=0.
- lb / lhu: with mem_rdata=0x80FF7F01:
  - lb at 0x2002 -> resp_rdata=0xFFFFFFFF.
  - lhu at 0x2002 -> 0x000080FF.
  - lb at 0x2001 -> 0x0000007F.
- lw: addr=0x3000, mem_resp delayed 5 cycles -> stall high for 6 cycles, strobes stable throughout, resp_rdata=mem_rdata, exactly one resp_valid pulse.
- Misaligned / illegal:
  - lw at 0x3002 -> no mem_read ever, resp_valid+resp_err in cycle 1.
  - Same result for req_read=req_write=1.
- Timeout: TIMEOUT_CYCLES=4, mem_resp never asserted -> strobes drop after 4 BUSY cycles, resp_err=1, resp_rdata=0.
- Reset in BUSY: rst asserted in the 2nd BUSY cycle -> next cycle mem_read=0, resp_valid=0, state IDLE. A mem_resp pulse afterwards produces no resp_valid.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared types for the data-memory access unit: FSM state encoding, the RV32I
// load/store funct3 encodings, the byte-write mask type, and a helper that
// decides whether a MEM-stage request can legally reach the bus.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef logic [3:0] rv32i_mem_wmask;

  // A request is rejected without touching the bus when it asks for both a
  // read and a write, names a funct3 with no load/store meaning, or is not
  // naturally aligned for its access size.
  function automatic logic req_illegal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (rd) begin
      case (f3)
        LB, LBU: bad = 1'b0;
        LH, LHU: bad = off[0];
        LW:      bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        SB:      bad = 1'b0;
        SH:      bad = off[0];
        SW:      bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Data-memory bus between the access unit and the cache/memory port.
//   mem_read / mem_write     : bus strobes, held until mem_resp
//   mem_address              : word-aligned byte address
//   mem_wdata                : lane-aligned store data
//   mem_byte_enable          : per-byte write mask
//   mem_resp                 : completion from memory
//   mem_rdata                : read data from memory
// master = access unit side, slave = memory side.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic           mem_read;
  logic           mem_write;
  logic [31:0]    mem_address;
  logic [31:0]    mem_wdata;
  rv32i_mem_wmask mem_byte_enable;
  logic           mem_resp;
  logic [31:0]    mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_resp,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_resp,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_unit_mem_align.sv
// mem_align
// Purely combinational byte-lane steering for the access unit.
//   stFunct3_i/stOff_i/stWdata_i : store request -> stWdata_o (replicated
//                                  across lanes) and stByteEnable_o
//   ldFunct3_i/ldOff_i/ldRdata_i : load request + bus word -> ldData_o
//                                  (selected bytes, sign/zero-extended)
// Unknown funct3 values produce zero outputs; the caller never uses them.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]     stFunct3_i,
  input  logic [1:0]     stOff_i,
  input  logic [31:0]    stWdata_i,
  output logic [31:0]    stWdata_o,
  output rv32i_mem_wmask stByteEnable_o,
  input  logic [2:0]     ldFunct3_i,
  input  logic [1:0]     ldOff_i,
  input  logic [31:0]    ldRdata_i,
  output logic [31:0]    ldData_o
);

  logic [31:0] ldShifted;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  // Stores replicate the low byte/half into every lane so the memory only
  // needs the byte enable to pick the right one.
  always_comb begin
    stWdata_o      = '0;
    stByteEnable_o = '0;
    case (stFunct3_i)
      SB: begin
        stByteEnable_o = 4'b0001 << stOff_i;
        stWdata_o      = {4{stWdata_i[7:0]}};
      end
      SH: begin
        stByteEnable_o = 4'b0011 << stOff_i;
        stWdata_o      = {2{stWdata_i[15:0]}};
      end
      SW: begin
        stByteEnable_o = 4'b1111;
        stWdata_o      = stWdata_i;
      end
      default: ;
    endcase
  end

  // Loads shift the addressed byte down to lane 0; halfwords only ever sit
  // in the lower or upper half, so the upper offset bit picks between them.
  always_comb begin
    ldShifted = ldRdata_i >> {ldOff_i, 3'b000};
    ldByte    = ldShifted[7:0];
    ldHalf    = ldOff_i[1] ? ldRdata_i[31:16] : ldRdata_i[15:0];
    ldData_o  = '0;
    case (ldFunct3_i)
      LB:      ldData_o = {{24{ldByte[7]}}, ldByte};
      LBU:     ldData_o = {24'h0, ldByte};
      LH:      ldData_o = {{16{ldHalf[15]}}, ldHalf};
      LHU:     ldData_o = {16'h0, ldHalf};
      LW:      ldData_o = ldRdata_i;
      default: ldData_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Turns the MEM-stage load/store intent into a data-memory bus transaction
// and stalls the pipeline until it completes.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/read/write     : MEM-stage control word
//   req_funct3/addr/wdata    : access width/sign, byte address, rs2 value
//   stall                    : hold the pipeline (combinational)
//   resp_valid               : one-cycle completion pulse
//   resp_rdata / resp_err    : extended load data / rejected-or-timed-out flag
//   bus                      : data-memory bus (master side)
// TIMEOUT_CYCLES bounds the wait for mem_resp; 0 waits forever.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  mau_state_t     state_q, state_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [1:0]     off_q, off_d;
  logic           isRead_q, isRead_d;
  logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic           memRead_q, memRead_d;
  logic           memWrite_q, memWrite_d;
  logic [31:0]    memAddress_q, memAddress_d;
  logic [31:0]    memWdata_q, memWdata_d;
  rv32i_mem_wmask memByteEnable_q, memByteEnable_d;
  logic [31:0]    respRdata_q, respRdata_d;
  logic           respErr_q, respErr_d;

  logic           op;
  logic           illegal;
  logic [CNT_W-1:0] timeoutInc;
  logic [31:0]    alignWdata;
  rv32i_mem_wmask alignByteEnable;
  logic [31:0]    loadData;

  // Store steering works on the live request (it is registered on accept);
  // load extraction works on the captured request and the live bus word.
  mem_align uAlign (
    .stFunct3_i     (req_funct3),
    .stOff_i        (req_addr[1:0]),
    .stWdata_i      (req_wdata),
    .stWdata_o      (alignWdata),
    .stByteEnable_o (alignByteEnable),
    .ldFunct3_i     (funct3_q),
    .ldOff_i        (off_q),
    .ldRdata_i      (bus.mem_rdata),
    .ldData_o       (loadData)
  );

  assign op         = req_valid & (req_read | req_write);
  assign illegal    = req_illegal(req_read, req_write, req_funct3, req_addr[1:0]);
  assign timeoutInc = timeoutCnt_q + CNT_W'(1);

  // Stall is released in DONE so the pipeline advances on the same edge
  // that retires the access.
  assign stall      = op & (state_q != DONE);
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

  assign bus.mem_read        = memRead_q;
  assign bus.mem_write       = memWrite_q;
  assign bus.mem_address     = memAddress_q;
  assign bus.mem_wdata       = memWdata_q;
  assign bus.mem_byte_enable = memByteEnable_q;

  // Next-state logic: accept and classify in IDLE, hold the bus in BUSY
  // until memory answers or the watchdog expires, then pulse DONE once.
  always_comb begin
    state_d         = state_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    isRead_d        = isRead_q;
    timeoutCnt_d    = timeoutCnt_q;
    memRead_d       = memRead_q;
    memWrite_d      = memWrite_q;
    memAddress_d    = memAddress_q;
    memWdata_d      = memWdata_q;
    memByteEnable_d = memByteEnable_q;
    respRdata_d     = respRdata_q;
    respErr_d       = respErr_q;

    case (state_q)
      IDLE: begin
        if (op) begin
          funct3_d     = req_funct3;
          off_d        = req_addr[1:0];
          isRead_d     = req_read;
          timeoutCnt_d = '0;
          respRdata_d  = '0;
          if (illegal) begin
            respErr_d = 1'b1;
            state_d   = DONE;
          end else begin
            respErr_d    = 1'b0;
            state_d      = BUSY;
            memRead_d    = req_read;
            memWrite_d   = req_write;
            memAddress_d = {req_addr[31:2], 2'b00};
            if (req_read) begin
              memWdata_d      = '0;
              memByteEnable_d = 4'b1111;
            end else begin
              memWdata_d      = alignWdata;
              memByteEnable_d = alignByteEnable;
            end
          end
        end
      end
      BUSY: begin
        if (bus.mem_resp) begin
          memRead_d   = 1'b0;
          memWrite_d  = 1'b0;
          respRdata_d = isRead_q ? loadData : '0;
          state_d     = DONE;
        end else begin
          timeoutCnt_d = timeoutInc;
          if (TIMEOUT_EN && (timeoutInc == TIMEOUT_LIMIT)) begin
            memRead_d   = 1'b0;
            memWrite_d  = 1'b0;
            respErr_d   = 1'b1;
            respRdata_d = '0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers; reset drops the strobes immediately so a
  // late mem_resp lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      funct3_q        <= '0;
      off_q           <= '0;
      isRead_q        <= 1'b0;
      timeoutCnt_q    <= '0;
      memRead_q       <= 1'b0;
      memWrite_q      <= 1'b0;
      memAddress_q    <= '0;
      memWdata_q      <= '0;
      memByteEnable_q <= '0;
      respRdata_q     <= '0;
      respErr_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      isRead_q        <= isRead_d;
      timeoutCnt_q    <= timeoutCnt_d;
      memRead_q       <= memRead_d;
      memWrite_q      <= memWrite_d;
      memAddress_q    <= memAddress_d;
      memWdata_q      <= memWdata_d;
      memByteEnable_q <= memByteEnable_d;
      respRdata_q     <= respRdata_d;
      respErr_q       <= respErr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. dutA uses the default timeout and
// is driven through hand-built vectors and random transactions; dutT shares
// the request inputs but has a 4-cycle timeout and a memory that never
// answers, and is only examined in the timeout sequence.
module tb_mem_access_unit;

  typedef struct {
    logic        read;
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        expErr;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
    int          expStall;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqRead = 1'b0;
  logic        reqWrite = 1'b0;
  logic [2:0]  reqFunct3 = 3'b000;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWdata = 32'h0;

  logic        stallA, respValidA, respErrA;
  logic [31:0] respRdataA;
  logic        stallT, respValidT, respErrT;
  logic [31:0] respRdataT;

  int vecCount = 0;
  int missCount = 0;

  txn_t vectors[14];

  mem_access_unit_if busA();
  mem_access_unit_if busT();

  always #5 clk = ~clk;

  mem_access_unit dutA (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_read   (reqRead),
    .req_write  (reqWrite),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .stall      (stallA),
    .resp_valid (respValidA),
    .resp_rdata (respRdataA),
    .resp_err   (respErrA),
    .bus        (busA)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dutT (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_read   (reqRead),
    .req_write  (reqWrite),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .stall      (stallT),
    .resp_valid (respValidT),
    .resp_rdata (respRdataT),
    .resp_err   (respErrT),
    .bus        (busT)
  );

  // Every comparison funnels through here so the summary counts are exact.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drives the shared MEM-stage request inputs.
  task automatic applyStimulus(input logic v, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd);
    reqValid  = v;
    reqRead   = rd;
    reqWrite  = wr;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wd;
  endtask

  // Holds reset for two edges; returns 1 time unit after a rising edge.
  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference behaviour derived from access size, alignment and lane
  // arithmetic rather than from any bit-level mux structure.
  function automatic txn_t modelTxn(input txn_t t);
    txn_t        r;
    int          size;
    int          off;
    logic        f3Ok;
    logic        legal;
    logic [31:0] sh;
    r    = t;
    off  = int'(t.addr % 4);
    size = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
    f3Ok = t.read ? (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (t.f3 <= 3'd2);
    legal = (t.read != t.write) && f3Ok && ((off % size) == 0);
    r.expErr   = !legal;
    r.expStall = legal ? t.delay + 2 : 1;
    r.expAddr  = t.addr & 32'hFFFF_FFFC;
    r.expRdata = 32'h0;
    if (t.read) begin
      r.expBe    = 4'hF;
      r.expWdata = 32'h0;
      sh = t.rdata >> (8 * off);
      if (size == 1)
        r.expRdata = (sh & 32'hFF) | ((sh[7] && !t.f3[2]) ? 32'hFFFF_FF00 : 32'h0);
      else if (size == 2)
        r.expRdata = (sh & 32'hFFFF) | ((sh[15] && !t.f3[2]) ? 32'hFFFF_0000 : 32'h0);
      else
        r.expRdata = t.rdata;
      if (!legal) r.expRdata = 32'h0;
    end else begin
      r.expBe = 4'(((1 << size) - 1) << off);
      if (size == 1)      r.expWdata = (t.wdata & 32'hFF) * 32'h0101_0101;
      else if (size == 2) r.expWdata = (t.wdata & 32'hFFFF) * 32'h0001_0001;
      else                r.expWdata = t.wdata;
    end
    return r;
  endfunction

  // Runs one transaction on dutA, answering after t.delay BUSY cycles and
  // scrambling the request inputs while BUSY. Entered and left 1 unit after
  // a rising edge with dutA idle.
  task automatic runTxn(input txn_t t, input string name);
    int stalls;
    stalls = 0;
    applyStimulus(1'b1, t.read, t.write, t.f3, t.addr, t.wdata);
    busA.mem_resp  = 1'b0;
    busA.mem_rdata = t.rdata;
    @(negedge clk);
    checkOutput({name, " idle strobes"}, 32'({busA.mem_read, busA.mem_write}), 32'h0);
    if (stallA) stalls++;
    @(posedge clk); #1;
    if (!t.expErr) begin
      for (int b = 0; b <= t.delay; b++) begin
        busA.mem_resp = (b == t.delay);
        reqAddr   = $urandom;
        reqWdata  = $urandom;
        reqFunct3 = 3'($urandom_range(0, 7));
        @(negedge clk);
        checkOutput({name, " busy rd"}, 32'(busA.mem_read), 32'(t.read));
        checkOutput({name, " busy wr"}, 32'(busA.mem_write), 32'(t.write));
        checkOutput({name, " busy addr"}, busA.mem_address, t.expAddr);
        checkOutput({name, " busy be"}, 32'(busA.mem_byte_enable), 32'(t.expBe));
        checkOutput({name, " busy wdata"}, busA.mem_wdata, t.expWdata);
        checkOutput({name, " busy resp_valid"}, 32'(respValidA), 32'h0);
        if (stallA) stalls++;
        @(posedge clk); #1;
      end
      busA.mem_resp = 1'b0;
    end
    @(negedge clk);
    checkOutput({name, " done resp_valid"}, 32'(respValidA), 32'h1);
    checkOutput({name, " done err"}, 32'(respErrA), 32'(t.expErr));
    checkOutput({name, " done rdata"}, respRdataA, t.expRdata);
    checkOutput({name, " done strobes"}, 32'({busA.mem_read, busA.mem_write}), 32'h0);
    checkOutput({name, " done stall"}, 32'(stallA), 32'h0);
    checkOutput({name, " stall cycles"}, 32'(stalls), 32'(t.expStall));
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({name, " single pulse"}, 32'(respValidA), 32'h0);
    @(posedge clk); #1;
  endtask

  // Bounds total run time in case the bench or DUT wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t t;

    //             rd    wr    f3      addr        wdata         rdata         dly err   expAddr     be       expWdata      expRdata      stall
    vectors[0]  = '{1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00AB, 32'h0,         0, 1'b0, 32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0,         2};
    vectors[1]  = '{1'b1, 1'b0, 3'b000, 32'h2002, 32'h0,         32'h80FF_7F01, 0, 1'b0, 32'h2000, 4'b1111, 32'h0,         32'hFFFF_FFFF, 2};
    vectors[2]  = '{1'b1, 1'b0, 3'b101, 32'h2002, 32'h0,         32'h80FF_7F01, 0, 1'b0, 32'h2000, 4'b1111, 32'h0,         32'h0000_80FF, 2};
    vectors[3]  = '{1'b1, 1'b0, 3'b000, 32'h2001, 32'h0,         32'h80FF_7F01, 0, 1'b0, 32'h2000, 4'b1111, 32'h0,         32'h0000_007F, 2};
    vectors[4]  = '{1'b1, 1'b0, 3'b010, 32'h3000, 32'h0,         32'h1234_5678, 4, 1'b0, 32'h3000, 4'b1111, 32'h0,         32'h1234_5678, 6};
    vectors[5]  = '{1'b1, 1'b0, 3'b010, 32'h3002, 32'h0,         32'h1234_5678, 0, 1'b1, 32'h0,    4'b0000, 32'h0,         32'h0,         1};
    vectors[6]  = '{1'b1, 1'b1, 3'b010, 32'h3000, 32'h5555_5555, 32'h1234_5678, 0, 1'b1, 32'h0,    4'b0000, 32'h0,         32'h0,         1};
    vectors[7]  = '{1'b0, 1'b1, 3'b001, 32'h1002, 32'h1234_CDEF, 32'h0,         0, 1'b0, 32'h1000, 4'b1100, 32'hCDEF_CDEF, 32'h0,         2};
    vectors[8]  = '{1'b1, 1'b0, 3'b001, 32'h2000, 32'h0,         32'h0000_8001, 1, 1'b0, 32'h2000, 4'b1111, 32'h0,         32'hFFFF_8001, 3};
    vectors[9]  = '{1'b0, 1'b1, 3'b010, 32'h1004, 32'hDEAD_BEEF, 32'h0,         2, 1'b0, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 32'h0,         4};
    vectors[10] = '{1'b0, 1'b1, 3'b011, 32'h1000, 32'h1111_1111, 32'h0,         0, 1'b1, 32'h0,    4'b0000, 32'h0,         32'h0,         1};
    vectors[11] = '{1'b1, 1'b0, 3'b110, 32'h2000, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 32'h0,    4'b0000, 32'h0,         32'h0,         1};
    vectors[12] = '{1'b1, 1'b0, 3'b001, 32'h2003, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 32'h0,    4'b0000, 32'h0,         32'h0,         1};
    vectors[13] = '{1'b1, 1'b0, 3'b100, 32'h2003, 32'h0,         32'h80FF_7F01, 0, 1'b0, 32'h2000, 4'b1111, 32'h0,         32'h0000_0080, 2};

    busA.mem_resp  = 1'b0;
    busA.mem_rdata = 32'h0;
    busT.mem_resp  = 1'b0;
    busT.mem_rdata = 32'h0;

    applyReset();
    @(negedge clk);
    checkOutput("reset mem_read", 32'(busA.mem_read), 32'h0);
    checkOutput("reset mem_write", 32'(busA.mem_write), 32'h0);
    checkOutput("reset mem_address", busA.mem_address, 32'h0);
    checkOutput("reset mem_wdata", busA.mem_wdata, 32'h0);
    checkOutput("reset byte_enable", 32'(busA.mem_byte_enable), 32'h0);
    checkOutput("reset resp_valid", 32'(respValidA), 32'h0);
    checkOutput("reset resp_err", 32'(respErrA), 32'h0);
    checkOutput("reset resp_rdata", respRdataA, 32'h0);
    checkOutput("reset stall", 32'(stallA), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      runTxn(vectors[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind     = int'($urandom_range(0, 9));
      t        = vectors[0];
      t.read   = (kind == 0) || (kind < 5);
      t.write  = (kind == 0) || (kind >= 5);
      t.f3     = 3'($urandom_range(0, 7));
      t.addr   = $urandom;
      t.wdata  = $urandom;
      t.rdata  = $urandom;
      t.delay  = int'($urandom_range(0, 3));
      t = modelTxn(t);
      runTxn(t, $sformatf("rand%0d", i));
    end

    // Reset while dutA waits on the bus, then a stray mem_resp.
    busA.mem_resp  = 1'b0;
    busA.mem_rdata = 32'hCAFE_F00D;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h5000, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstbusy busy1 rd", 32'(busA.mem_read), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstbusy busy2 rd", 32'(busA.mem_read), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rstbusy after rd", 32'(busA.mem_read), 32'h0);
    checkOutput("rstbusy after resp_valid", 32'(respValidA), 32'h0);
    checkOutput("rstbusy after stall", 32'(stallA), 32'h0);
    @(posedge clk); #1;
    busA.mem_resp = 1'b1;
    @(negedge clk);
    checkOutput("rstbusy stray resp", 32'(respValidA), 32'h0);
    @(posedge clk); #1;
    busA.mem_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstbusy quiet%0d", k), 32'(respValidA), 32'h0);
      @(posedge clk); #1;
    end
    runTxn(vectors[0], "post-reset sb");

    // Timeout on dutT: memory never answers.
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0);
    @(negedge clk);
    checkOutput("tmo accept stall", 32'(stallT), 32'h1);
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checkOutput($sformatf("tmo busy%0d rd", b), 32'(busT.mem_read), 32'h1);
      checkOutput($sformatf("tmo busy%0d resp_valid", b), 32'(respValidT), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("tmo done resp_valid", 32'(respValidT), 32'h1);
    checkOutput("tmo done err", 32'(respErrT), 32'h1);
    checkOutput("tmo done rdata", respRdataT, 32'h0);
    checkOutput("tmo done rd", 32'(busT.mem_read), 32'h0);
    checkOutput("tmo done stall", 32'(stallT), 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    applyReset();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
